// File: rtl/misc_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : misc_writeback_arbiter
// Brief    : Three per-requester write FIFOs (rs232c, keyboard, sd) merged
//            round-robin onto a single registered misc register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
module misc_writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_enable,
    input  logic [4:0]  req_addr_rs,
    input  logic [4:0]  req_addr_kb,
    input  logic [4:0]  req_addr_sd,
    input  logic [31:0] req_data_rs,
    input  logic [31:0] req_data_kb,
    input  logic [31:0] req_data_sd,
    input  logic        req_float_rs,
    input  logic        req_float_kb,
    input  logic        req_float_sd,
    output logic        write_enable_misc,
    output logic [4:0]  write_addr_misc,
    output logic [31:0] write_data_misc,
    output logic        write_float_misc,
    output logic [2:0]  req_full,
    output logic [2:0]  overflow,
    output logic        busy
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    // Entry layout: {addr[4:0], float, data[31:0]}
    logic [2:0][37:0] w_req_entry;
    logic [2:0][37:0] w_head;
    logic [2:0]       w_nonempty;
    logic             w_grant_valid;
    logic [1:0]       w_grant_idx;
    logic [1:0]       w_start;

    logic [1:0]       r_last_grant;
    logic             r_wr_en;
    logic [4:0]       r_wr_addr;
    logic [31:0]      r_wr_data;
    logic             r_wr_float;

    assign w_req_entry[0] = {req_addr_rs, req_float_rs, req_data_rs};
    assign w_req_entry[1] = {req_addr_kb, req_float_kb, req_data_kb};
    assign w_req_entry[2] = {req_addr_sd, req_float_sd, req_data_sd};

    for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
        logic [37:0]        r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_wr_ptr;
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [c_cnt_w-1:0] r_count;
        logic               r_overflow;
        logic               w_full;
        logic               w_pop;
        logic               w_push;
        logic               w_drop;

        // Full is taken from the stored count only; a same-cycle pop frees a slot
        // for the push but does not clear the flag.
        assign w_full = (r_count == c_full_cnt);
        assign w_pop  = w_grant_valid && (w_grant_idx == 2'(gi));
        assign w_push = req_enable[gi] && (!w_full || w_pop);
        assign w_drop = req_enable[gi] && w_full && !w_pop;

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_req_entry[gi];
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_w'(1);
                    2'b01:   r_count <= r_count - c_cnt_w'(1);
                    default: r_count <= r_count;
                endcase
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end

        assign w_nonempty[gi] = (r_count != '0);
        assign w_head[gi]     = r_mem[r_rd_ptr];
        assign req_full[gi]   = w_full;
        assign overflow[gi]   = r_overflow;
    end

    assign w_start = (r_last_grant == 2'd2) ? 2'd0 : r_last_grant + 2'd1;

    // Arbitration looks only at stored counts, so a fresh push waits a cycle.
    always_comb begin
        logic [1:0] w_scan;
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        w_scan        = w_start;
        for (int k = 0; k < 3; k++) begin
            if (!w_grant_valid && w_nonempty[w_scan]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_scan;
            end
            w_scan = (w_scan == 2'd2) ? 2'd0 : w_scan + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= 2'd2;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_float   <= 1'b0;
        end else begin
            r_wr_en <= w_grant_valid;
            if (w_grant_valid) begin
                r_last_grant <= w_grant_idx;
                {r_wr_addr, r_wr_float, r_wr_data} <= w_head[w_grant_idx];
            end else begin
                r_wr_addr  <= '0;
                r_wr_data  <= '0;
                r_wr_float <= 1'b0;
            end
        end
    end

    assign write_enable_misc = r_wr_en;
    assign write_addr_misc   = r_wr_addr;
    assign write_data_misc   = r_wr_data;
    assign write_float_misc  = r_wr_float;
    assign busy              = (|w_nonempty) | r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_misc_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_misc_writeback_arbiter
// Brief    : Directed self-checking bench for misc_writeback_arbiter (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_misc_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_enable;
    logic [4:0]  req_addr_rs, req_addr_kb, req_addr_sd;
    logic [31:0] req_data_rs, req_data_kb, req_data_sd;
    logic        req_float_rs, req_float_kb, req_float_sd;
    logic        write_enable_misc;
    logic [4:0]  write_addr_misc;
    logic [31:0] write_data_misc;
    logic        write_float_misc;
    logic [2:0]  req_full;
    logic [2:0]  overflow;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    misc_writeback_arbiter #(.DEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_enable        (req_enable),
        .req_addr_rs       (req_addr_rs),
        .req_addr_kb       (req_addr_kb),
        .req_addr_sd       (req_addr_sd),
        .req_data_rs       (req_data_rs),
        .req_data_kb       (req_data_kb),
        .req_data_sd       (req_data_sd),
        .req_float_rs      (req_float_rs),
        .req_float_kb      (req_float_kb),
        .req_float_sd      (req_float_sd),
        .write_enable_misc (write_enable_misc),
        .write_addr_misc   (write_addr_misc),
        .write_data_misc   (write_data_misc),
        .write_float_misc  (write_float_misc),
        .req_full          (req_full),
        .overflow          (overflow),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push tag n: addr=n, data=0x100*(req+1)+n, float set only for keyboard
    task automatic drive(input logic [2:0] en, input int n);
        req_enable   = en;
        req_addr_rs  = 5'(n);
        req_addr_kb  = 5'(n);
        req_addr_sd  = 5'(n);
        req_data_rs  = 32'h100 + 32'(n);
        req_data_kb  = 32'h200 + 32'(n);
        req_data_sd  = 32'h300 + 32'(n);
        req_float_rs = 1'b0;
        req_float_kb = 1'b1;
        req_float_sd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(3'b000, 0);
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(3'b111, 9);
        step();
        step();
        checks++;
        if ({write_enable_misc, write_addr_misc, write_float_misc, write_data_misc} !== 39'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b/%h/%b/%h required=0/00/0/00000000",
                     write_enable_misc, write_addr_misc, write_float_misc, write_data_misc);
        end
        checks++;
        if ({overflow, req_full, busy} !== 7'd0) begin
            failures++;
            $display("FAIL reset_flags actual ovf=%b full=%b busy=%b required 000/000/0",
                     overflow, req_full, busy);
        end
        reset = 1'b1;
        drive(3'b000, 0);
    endtask

    task automatic test_single_push();
        do_reset();
        req_enable   = 3'b010;
        req_addr_kb  = 5'd7;
        req_data_kb  = 32'hDEADBEEF;
        req_float_kb = 1'b1;
        step();
        checks++;
        if (write_enable_misc !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_no_bypass actual en=%b busy=%b required en=0 busy=1",
                     write_enable_misc, busy);
        end
        drive(3'b000, 0);
        step();
        checks++;
        if ({write_enable_misc, write_addr_misc, write_float_misc, write_data_misc}
                !== {1'b1, 5'd7, 1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_output actual=%b/%0d/%b/%h required=1/7/1/deadbeef",
                     write_enable_misc, write_addr_misc, write_float_misc, write_data_misc);
        end
        step();
        checks++;
        if (write_enable_misc !== 1'b0 || write_data_misc !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle actual en=%b data=%h busy=%b required 0/0/0",
                     write_enable_misc, write_data_misc, busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_data [3];
        exp_data = '{32'h105, 32'h205, 32'h305};
        do_reset();
        drive(3'b111, 5);
        step();
        drive(3'b000, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (write_enable_misc !== 1'b1 || write_data_misc !== exp_data[i]
                    || write_float_misc !== (i == 1)) begin
                failures++;
                $display("FAIL simul_order[%0d] actual en=%b data=%h fl=%b required 1/%h/%b",
                         i, write_enable_misc, write_data_misc, write_float_misc,
                         exp_data[i], (i == 1));
            end
        end
        step();
        checks++;
        if (write_enable_misc !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL simul_drain actual en=%b busy=%b required 0/0",
                     write_enable_misc, busy);
        end
    endtask

    task automatic test_round_robin();
        // Hand-derived grant owner / push tag seen after each edge t (index = t)
        int exp_g [20];
        int exp_n [20];
        logic [38:0] exp_word;
        exp_g = '{-1, -1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, -1};
        exp_n = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 0};
        do_reset();
        for (int t = 1; t <= 19; t++) begin
            if (t <= 12) drive(3'b111, t);
            else         drive(3'b000, 0);
            step();
            if (exp_g[t] < 0)
                exp_word = 39'd0;
            else
                exp_word = {1'b1, 5'(exp_n[t]), (exp_g[t] == 1),
                            32'h100 * 32'(exp_g[t] + 1) + 32'(exp_n[t])};
            checks++;
            if ({write_enable_misc, write_addr_misc, write_float_misc, write_data_misc}
                    !== exp_word) begin
                failures++;
                $display("FAIL rr_out[t=%0d] actual=%b/%0d/%b/%h required=%b/%0d/%b/%h", t,
                         write_enable_misc, write_addr_misc, write_float_misc, write_data_misc,
                         exp_word[38], exp_word[37:33], exp_word[32], exp_word[31:0]);
            end
            if (t == 3 || t == 4 || t == 12) begin
                checks++;
                if (overflow !== ((t == 3) ? 3'b100 : 3'b111)) begin
                    failures++;
                    $display("FAIL rr_overflow[t=%0d] actual=%b required=%b", t, overflow,
                             (t == 3) ? 3'b100 : 3'b111);
                end
            end
            if (t == 12) begin
                checks++;
                if (req_full !== 3'b111) begin
                    failures++;
                    $display("FAIL rr_full actual=%b required=111", req_full);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_drain_busy actual=%b required=0", busy);
        end
    endtask

    task automatic test_overflow();
        int exp_g [10];
        int exp_n [10];
        logic [38:0] exp_word;
        exp_g = '{-1, -1, 0, 1, 2, 0, 1, 2, 2, -1};
        exp_n = '{0, 0, 1, 1, 1, 2, 2, 2, 4, 0};
        do_reset();
        for (int t = 1; t <= 9; t++) begin
            case (t)
                1, 2:    drive(3'b111, t);
                3, 4:    drive(3'b100, t);
                default: drive(3'b000, 0);
            endcase
            step();
            if (exp_g[t] < 0)
                exp_word = 39'd0;
            else
                exp_word = {1'b1, 5'(exp_n[t]), (exp_g[t] == 1),
                            32'h100 * 32'(exp_g[t] + 1) + 32'(exp_n[t])};
            checks++;
            if ({write_enable_misc, write_addr_misc, write_float_misc, write_data_misc}
                    !== exp_word) begin
                failures++;
                $display("FAIL ovf_out[t=%0d] actual=%b/%0d/%b/%h required=%b/%0d/%b/%h", t,
                         write_enable_misc, write_addr_misc, write_float_misc, write_data_misc,
                         exp_word[38], exp_word[37:33], exp_word[32], exp_word[31:0]);
            end
            if (t == 2) begin
                checks++;
                if (req_full !== 3'b110 || overflow !== 3'b000) begin
                    failures++;
                    $display("FAIL ovf_t2 actual full=%b ovf=%b required 110/000", req_full, overflow);
                end
            end
            if (t == 3 || t == 4) begin
                checks++;
                if (req_full !== 3'b100 || overflow !== 3'b100) begin
                    failures++;
                    $display("FAIL ovf_t%0d actual full=%b ovf=%b required 100/100", t,
                             req_full, overflow);
                end
            end
        end
        checks++;
        if (overflow !== 3'b100 || req_full !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky actual ovf=%b full=%b busy=%b required 100/000/0",
                     overflow, req_full, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int t = 1; t <= 12; t++) begin
            drive(3'b000, 0);
            if (t <= 10) begin
                req_enable  = 3'b010;
                req_addr_kb = 5'(t);
                req_data_kb = 32'(t);
            end
            step();
            checks++;
            if (t == 1 || t == 12) begin
                if (write_enable_misc !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_idle[t=%0d] actual en=%b required 0", t, write_enable_misc);
                end
            end else if (write_enable_misc !== 1'b1 || write_data_misc !== 32'(t - 1)
                         || write_addr_misc !== 5'(t - 1)) begin
                failures++;
                $display("FAIL wrap_out[t=%0d] actual en=%b addr=%0d data=%0d required 1/%0d/%0d",
                         t, write_enable_misc, write_addr_misc, write_data_misc, t - 1, t - 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int t = 1; t <= 3; t++) begin
            drive(3'b111, 20 + t);
            step();
        end
        reset = 1'b0;
        drive(3'b111, 30);
        step();
        checks++;
        if ({write_enable_misc, write_addr_misc, write_float_misc, write_data_misc} !== 39'd0
                || busy !== 1'b0 || overflow !== 3'b000 || req_full !== 3'b000) begin
            failures++;
            $display("FAIL midreset_clear actual en=%b data=%h busy=%b ovf=%b full=%b required all 0",
                     write_enable_misc, write_data_misc, busy, overflow, req_full);
        end
        reset = 1'b1;
        drive(3'b000, 0);
        for (int t = 0; t < 6; t++) begin
            step();
            checks++;
            if (write_enable_misc !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset_stale[%0d] actual en=%b data=%h busy=%b required 0/0/0",
                         t, write_enable_misc, write_data_misc, busy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        drive(3'b000, 0);
        test_reset();
        test_single_push();
        test_simultaneous();
        test_round_robin();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/misc_writeback_arbiter.md
MISC_WRITEBACK_ARBITER -- requirements
Module: misc_writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, meaning entries per requester FIFO (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset==0 at a rising edge resets all state.
REQ-004 req_enable  input  3  per-requester write request pulse; bit0=rs232c, bit1=keyboard, bit2=sd.
REQ-005 req_addr_{rs,kb,sd}  input  5 each  destination register address.
REQ-006 req_data_{rs,kb,sd}  input  32 each  write data.
REQ-007 req_float_{rs,kb,sd}  input  1 each  1=float register file, 0=integer.
REQ-008 write_enable_misc  output  1  register-manager misc write strobe.
REQ-009 write_addr_misc / write_data_misc / write_float_misc  output  5/32/1  granted write.
REQ-010 req_full  output  3  per-requester FIFO full flag.
REQ-011 overflow  output  3  sticky per-requester dropped-write flag.
REQ-012 busy  output  1  1 when any FIFO non-empty or an output write is valid.

Function
REQ-013 Each requester SHALL own a DEPTH-entry FIFO of {addr,float,data}; req_enable[i]=1 at an edge pushes that requester's inputs.
REQ-014 Push to a full FIFO with no same-cycle pop SHALL drop the entry, leave FIFO unchanged, and set overflow[i]=1 until reset.
REQ-015 Push and pop on the same FIFO in one cycle SHALL both occur; count unchanged; no overflow even when full.
REQ-016 Push to an empty FIFO SHALL NOT be bypassed: entry is arbitrated no earlier than the cycle after the push.
REQ-017 Each cycle the arbiter SHALL grant at most one non-empty FIFO, popping its head.
REQ-018 Grant order SHALL be round-robin: search starts at index (last_grant+1) mod 3, ascending modulo 3, first non-empty wins.
REQ-019 last_grant SHALL update only on a grant; with no grant it holds.
REQ-020 Outputs SHALL be registered: the head popped at edge E appears on write_*_misc after edge E, with write_enable_misc=1 for exactly one cycle.
REQ-021 Cycle with no grant: write_enable_misc=0, write_addr_misc=0, write_data_misc=0, write_float_misc=0.
REQ-022 Minimum latency push-to-output SHALL be 2 edges (push at E, pop at E+1, visible after E+1).
REQ-023 req_full[i] SHALL be combinational from FIFO count (count==DEPTH), not from the same-cycle pop.
REQ-024 Pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1; no entry lost or duplicated at wrap.
REQ-025 Sustained requests on all three SHALL give each requester exactly one grant per 3 cycles.
REQ-026 Entries from one requester SHALL be written in push order.
REQ-027 busy = (any count!=0) OR write_enable_misc.

Reset
REQ-028 On reset: all FIFO counts and pointers 0, last_grant=2 (first priority rs232c), all write_*_misc 0, overflow=3'b000, req_full=3'b000, busy=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries; pushes in a reset cycle SHALL be ignored.
REQ-030 FIFO storage need not be cleared; no stale entry SHALL ever be emitted after reset.

Verification
REQ-031 Single push: req_enable=3'b010, addr=7, data=32'hDEADBEEF, float=1 at E -> after E+1 enable=1, addr=7, data=DEADBEEF, float=1 for one cycle; busy back to 0 after E+2.
REQ-032 Simultaneous push all three at E after reset -> outputs after E+1,E+2,E+3 in order rs, kb, sd; no gaps.
REQ-033 Round-robin: all three requesters push every cycle for 12 cycles (DEPTH=2) -> grants cycle rs,kb,sd repeatedly; no overflow because pop-while-full allowed on granted FIFO; overflow set only on non-granted full FIFOs, checked against model.
REQ-034 Overflow: push sd 4 times consecutively while rs and kb hold FIFOs non-empty with higher priority -> req_full[2]=1, overflow[2]=1 sticky, only non-dropped data emitted in order.
REQ-035 Wrap: DEPTH=2, 10 sequential pushes on kb with data 1..10 spaced 1 cycle -> output data 1..10 exactly once, in order.
REQ-036 Reset mid-queue: fill all FIFOs, assert reset=0 one cycle -> next cycle all outputs 0, busy=0, no queued entry ever appears.
